// File: rtl/fp_flag_if.sv
// Handshake/status bundle between the FIR multiplier datapath and the FP flag controller.
interface fp_flag_if #(
  parameter int WFLAG   = 5,
  parameter int OPCNT_W = 16
);
  logic               in_valid;
  logic [WFLAG-1:0]   in_flags;
  logic               in_ready;
  logic [WFLAG-1:0]   trap_mask;
  logic               trap;
  logic [WFLAG-1:0]   trap_cause;
  logic               trap_ack;
  logic               clr_req;
  logic [WFLAG-1:0]   clr_mask;
  logic               clr_ack;
  logic [WFLAG-1:0]   sticky;
  logic [OPCNT_W-1:0] op_count;

  modport master (
    output in_valid, in_flags, trap_mask, trap_ack, clr_req, clr_mask,
    input  in_ready, trap, trap_cause, clr_ack, sticky, op_count
  );

  modport slave (
    input  in_valid, in_flags, trap_mask, trap_ack, clr_req, clr_mask,
    output in_ready, trap, trap_cause, clr_ack, sticky, op_count
  );
endinterface

// File: rtl/fp_flag_ctrl.sv
// IEEE exception-flag sticky/trap/clear sequencer for the FIR multiplier datapath.
// Define FP_FLAG_CNT_EN to add per-flag saturating event counters (flag_cnt port).
module fp_flag_ctrl #(
  parameter int WFLAG   = 5,
  parameter int OPCNT_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  fp_flag_if.slave bus
`ifdef FP_FLAG_CNT_EN
  ,
  output logic [WFLAG*CNT_W-1:0] flag_cnt
`endif
);

  typedef enum logic [1:0] {RUN, TRAP, CLR} state_e;

  state_e             state_q, state_d;
  logic [WFLAG-1:0]   sticky_q, sticky_d;
  logic [WFLAG-1:0]   cause_q, cause_d;
  logic [WFLAG-1:0]   clr_mask_q, clr_mask_d;
  logic [OPCNT_W-1:0] op_count_q, op_count_d;
  logic               xfer;

  // in_ready is a pure state decode, so acceptance never depends combinationally on inputs
  assign xfer = bus.in_valid && (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    sticky_d   = sticky_q;
    cause_d    = cause_q;
    clr_mask_d = clr_mask_q;
    op_count_d = op_count_q;
    case (state_q)
      RUN: begin
        if (xfer) begin
          sticky_d   = sticky_q | bus.in_flags;
          op_count_d = op_count_q + 1'b1;
        end
        // a trapping transfer drops any same-cycle clear; the requester retries
        if (xfer && |(bus.in_flags & bus.trap_mask)) begin
          state_d = TRAP;
          cause_d = bus.in_flags & bus.trap_mask;
        end else if (bus.clr_req) begin
          state_d    = CLR;
          clr_mask_d = bus.clr_mask;
        end
      end
      TRAP: begin
        if (bus.trap_ack) begin
          state_d = RUN;
          cause_d = '0;
        end
      end
      CLR: begin
        sticky_d = sticky_q & ~clr_mask_q;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sticky_q   <= '0;
      cause_q    <= '0;
      clr_mask_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      cause_q    <= cause_d;
      clr_mask_q <= clr_mask_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.in_ready   = (state_q == RUN);
  assign bus.trap       = (state_q == TRAP);
  assign bus.clr_ack    = (state_q == CLR);
  assign bus.trap_cause = cause_q;
  assign bus.sticky     = sticky_q;
  assign bus.op_count   = op_count_q;

`ifdef FP_FLAG_CNT_EN
  for (genvar i = 0; i < WFLAG; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == CLR && clr_mask_q[i])
        cnt_d = '0;
      else if (xfer && bus.in_flags[i] && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign flag_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fp_flag_ctrl.sv
// Directed table-driven bench for fp_flag_ctrl plus hand-written reset/wrap/counter sequences.
module tb_fp_flag_ctrl;
  localparam int WFLAG   = 5;
  localparam int OPCNT_W = 8;
  localparam int CNT_W   = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  fp_flag_if #(.WFLAG(WFLAG), .OPCNT_W(OPCNT_W)) bus ();

`ifdef FP_FLAG_CNT_EN
  logic [WFLAG*CNT_W-1:0] flag_cnt;
`endif

  fp_flag_ctrl #(.WFLAG(WFLAG), .OPCNT_W(OPCNT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FP_FLAG_CNT_EN
    ,
    .flag_cnt (flag_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [WFLAG-1:0] flags;
    logic [WFLAG-1:0] tmask;
    logic             ack;
    logic             creq;
    logic [WFLAG-1:0] cmask;
    logic [WFLAG-1:0] e_sticky;
    logic             e_trap;
    logic [WFLAG-1:0] e_cause;
    logic             e_clr;
    logic             e_ready;
    logic [OPCNT_W-1:0] e_op;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WFLAG-1:0] f, input logic [WFLAG-1:0] tm,
                       input logic a, input logic cr, input logic [WFLAG-1:0] cm);
    bus.in_valid  = v;
    bus.in_flags  = f;
    bus.trap_mask = tm;
    bus.trap_ack  = a;
    bus.clr_req   = cr;
    bus.clr_mask  = cm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         valid flags    tmask    ack creq cmask   | sticky   trap cause    clr rdy op
    vt[0]  = '{1'b1, 5'b00100, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00100, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd1};
    vt[1]  = '{1'b1, 5'b00100, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00100, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd2};
    vt[2]  = '{1'b1, 5'b00100, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00100, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd3};
    vt[3]  = '{1'b1, 5'b01100, 5'b01000, 1'b0, 1'b0, 5'b00000, 5'b01100, 1'b1, 5'b01000, 1'b0, 1'b0, 8'd4};
    vt[4]  = '{1'b1, 5'b00001, 5'b01000, 1'b0, 1'b0, 5'b00000, 5'b01100, 1'b1, 5'b01000, 1'b0, 1'b0, 8'd4};
    vt[5]  = '{1'b1, 5'b00001, 5'b01000, 1'b0, 1'b0, 5'b00000, 5'b01100, 1'b1, 5'b01000, 1'b0, 1'b0, 8'd4};
    vt[6]  = '{1'b1, 5'b00001, 5'b01000, 1'b0, 1'b0, 5'b00000, 5'b01100, 1'b1, 5'b01000, 1'b0, 1'b0, 8'd4};
    vt[7]  = '{1'b1, 5'b00001, 5'b01000, 1'b0, 1'b0, 5'b00000, 5'b01100, 1'b1, 5'b01000, 1'b0, 1'b0, 8'd4};
    vt[8]  = '{1'b1, 5'b00001, 5'b01000, 1'b1, 1'b0, 5'b00000, 5'b01100, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd4};
    vt[9]  = '{1'b1, 5'b00001, 5'b01000, 1'b0, 1'b0, 5'b00000, 5'b01101, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd5};
    vt[10] = '{1'b1, 5'b10010, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b11111, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd6};
    vt[11] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 5'b00110, 5'b11111, 1'b0, 5'b00000, 1'b1, 1'b0, 8'd6};
    vt[12] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b11001, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd6};
    vt[13] = '{1'b1, 5'b00001, 5'b00000, 1'b0, 1'b1, 5'b00001, 5'b11001, 1'b0, 5'b00000, 1'b1, 1'b0, 8'd7};
    vt[14] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b11000, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd7};
    vt[15] = '{1'b1, 5'b00001, 5'b00001, 1'b0, 1'b1, 5'b00001, 5'b11001, 1'b1, 5'b00001, 1'b0, 1'b0, 8'd8};
    vt[16] = '{1'b0, 5'b00000, 5'b00001, 1'b0, 1'b0, 5'b00000, 5'b11001, 1'b1, 5'b00001, 1'b0, 1'b0, 8'd8};
    vt[17] = '{1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b11001, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd8};
    vt[18] = '{1'b0, 5'b00000, 5'b11111, 1'b1, 1'b0, 5'b00000, 5'b11001, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd8};
    vt[19] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 5'b11111, 5'b11001, 1'b0, 5'b00000, 1'b1, 1'b0, 8'd8};
    vt[20] = '{1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1, 8'd8};

    // reset state, then traffic, then async reset mid-traffic
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #12;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_trap", bus.trap, 0);
    chk("rst_sticky", bus.sticky, 0);
    chk("rst_op", bus.op_count, 0);
    chk("rst_clr_ack", bus.clr_ack, 0);
    rst_n = 1'b1;
    drive(1'b1, 5'b11111, 5'b00000, 1'b0, 1'b0, '0);
    tick();
    tick();
    chk("pre_sticky", bus.sticky, 5'b11111);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sticky", bus.sticky, 0);
    chk("midrst_op", bus.op_count, 0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].valid, vt[i].flags, vt[i].tmask, vt[i].ack, vt[i].creq, vt[i].cmask);
      tick();
      chk($sformatf("v%0d_sticky", i), bus.sticky,     vt[i].e_sticky);
      chk($sformatf("v%0d_trap", i),   bus.trap,       vt[i].e_trap);
      chk($sformatf("v%0d_cause", i),  bus.trap_cause, vt[i].e_cause);
      chk($sformatf("v%0d_clr", i),    bus.clr_ack,    vt[i].e_clr);
      chk($sformatf("v%0d_ready", i),  bus.in_ready,   vt[i].e_ready);
      chk($sformatf("v%0d_op", i),     bus.op_count,   vt[i].e_op);
    end

    // op_count wrap: 2^OPCNT_W+2 transfers from zero
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b1, 5'b00100, 5'b00000, 1'b0, 1'b0, '0);
    for (int i = 0; i < (1 << OPCNT_W) + 2; i++) tick();
    chk("wrap_op", bus.op_count, 2);
    chk("wrap_sticky", bus.sticky, 5'b00100);
    for (int i = 0; i < 42; i++) tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
`ifdef FP_FLAG_CNT_EN
    chk("cnt_inexact_sat", flag_cnt[2*CNT_W +: CNT_W], 255);
    chk("cnt_other", flag_cnt[0 +: CNT_W], 0);
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b1, 5'b00100);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("clr_after_wrap", bus.sticky, 0);
`ifdef FP_FLAG_CNT_EN
    chk("cnt_cleared", flag_cnt[2*CNT_W +: CNT_W], 0);
`endif

    // async reset while trap pending
    drive(1'b1, 5'b00010, 5'b00010, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, '0, 5'b00010, 1'b0, 1'b0, '0);
    chk("trap_set", bus.trap, 1);
    chk("trap_cause_set", bus.trap_cause, 5'b00010);
    #2 rst_n = 1'b0;
    #1;
    chk("trprst_trap", bus.trap, 0);
    chk("trprst_cause", bus.trap_cause, 0);
    chk("trprst_sticky", bus.sticky, 0);
    chk("trprst_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
